// File: rtl/serial_sender.sv
// UART-style serial transmitter: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// A one-byte holding register allows back-to-back frames with no idle gap on the line.
module serial_sender #(
  parameter int SAMPLE_RATIO = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       sample_clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       send,
  output logic       ready,
  output logic       busy,
  output logic       dout
);

  localparam int CW = (SAMPLE_RATIO > 1) ? $clog2(SAMPLE_RATIO) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SAMPLE_RATIO - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [7:0]    hold_q, hold_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          dout_q, dout_d;
  logic          bitEnd;
  logic          load;

  assign bitEnd = (cnt_q == CNT_LAST);

  // Next-state logic; idx counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_d = state_q;
    cnt_d   = bitEnd ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    hold_d  = hold_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    load    = 1'b0;

    if (send && ready_q) begin
      hold_d  = din;
      ready_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        dout_d = 1'b1;
        busy_d = 1'b0;
        if (!ready_q) load = 1'b1;
      end
      S_START: begin
        if (bitEnd) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          dout_d  = shift_q[0];
        end
      end
      S_DATA: begin
        if (bitEnd) begin
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              dout_d  = par_q;
            end else begin
              state_d = S_STOP;
              dout_d  = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            dout_d  = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bitEnd) begin
          state_d = S_STOP;
          idx_d   = 3'd0;
          dout_d  = 1'b1;
        end
      end
      S_STOP: begin
        if (bitEnd) begin
          if (idx_q == LAST_STOP) begin
            if (!ready_q) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              dout_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        dout_d  = 1'b1;
      end
    endcase

    // Parity is taken from the held byte at load time, not from the shifting copy.
    if (load) begin
      state_d = S_START;
      cnt_d   = '0;
      idx_d   = 3'd0;
      shift_d = hold_q;
      par_d   = (^hold_q) ^ ODD_PAR;
      ready_d = 1'b1;
      busy_d  = 1'b1;
      dout_d  = 1'b0;
    end
  end

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      hold_q  <= 8'h00;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      dout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_serial_sender.sv
// Directed bench for serial_sender: a default instance (16x, no parity, 1 stop)
// and a 4x / even parity / 2 stop instance sharing one clock.
module tb_serial_sender;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       send;
  logic       ready, busy, dout;
  logic [7:0] pDin;
  logic       pSend;
  logic       pReady, pBusy, pDout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_sender u_dut (
    .sample_clk(clk), .reset(reset), .din(din), .send(send),
    .ready(ready), .busy(busy), .dout(dout)
  );

  serial_sender #(.SAMPLE_RATIO(4), .PARITY(2), .STOP_BITS(2)) u_par (
    .sample_clk(clk), .reset(reset), .din(pDin), .send(pSend),
    .ready(pReady), .busy(pBusy), .dout(pDout)
  );

  // Outputs are observed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after the accepting edge (k=1 is the first start cycle).
  function automatic logic expBit(input int k, input logic [7:0] b, input int sr,
                                  input int par, input int stops);
    int slot;
    slot = (k - 1) / sr;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (par != 0 && slot == 9) return (par == 2) ? ^b : ~^b;
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; send = 1'b0; pSend = 1'b0; din = 8'h00; pDin = 8'h00;
    repeat (3) tick();
    checks++; if (dout !== 1'b1)  begin errors++; $display("[TB] FAIL reset_dout: got %b expected 1", dout); end
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (pDout !== 1'b1) begin errors++; $display("[TB] FAIL reset_pdout: got %b expected 1", pDout); end
    reset = 1'b0;
    din = 8'h00; send = 1'b1; tick(); send = 1'b0;
    repeat (40) tick();
    checks++; if (busy !== 1'b1 || dout !== 1'b0) begin errors++; $display("[TB] FAIL midframe: got busy=%b dout=%b expected busy=1 dout=0", busy, dout); end
    reset = 1'b1;
    tick();
    checks++; if (dout !== 1'b1)  begin errors++; $display("[TB] FAIL abort_dout: got %b expected 1", dout); end
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready: got %b expected 1", ready); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      checks++;
      if (dout !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("[TB] FAIL idle_line cycle %0d: got dout=%b busy=%b expected dout=1 busy=0", k, dout, busy);
      end
    end
  endtask

  task automatic test_single();
    din = 8'hA5; send = 1'b1; tick(); send = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL accept_ready: got %b expected 0", ready); end
    checks++; if (dout !== 1'b1)  begin errors++; $display("[TB] FAIL accept_dout: got %b expected 1", dout); end
    for (int k = 1; k <= 160; k++) begin
      tick();
      checks++;
      if (dout !== expBit(k, 8'hA5, 16, 0, 1) || busy !== 1'b1 || ready !== 1'b1) begin
        errors++; $display("[TB] FAIL single k=%0d: got dout=%b busy=%b ready=%b expected dout=%b busy=1 ready=1",
                           k, dout, busy, ready, expBit(k, 8'hA5, 16, 0, 1));
      end
    end
    tick();
    checks++; if (busy !== 1'b0 || dout !== 1'b1) begin errors++; $display("[TB] FAIL single_end: got busy=%b dout=%b expected busy=0 dout=1", busy, dout); end
  endtask

  task automatic test_back_to_back();
    logic e;
    din = 8'h00; send = 1'b1; tick(); send = 1'b0;
    for (int k = 1; k <= 320; k++) begin
      if (k == 2) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready: got %b expected 1", ready); end
        din = 8'hFF; send = 1'b1;
      end
      tick();
      if (k == 2) send = 1'b0;
      e = (k <= 160) ? expBit(k, 8'h00, 16, 0, 1) : expBit(k - 160, 8'hFF, 16, 0, 1);
      checks++;
      if (dout !== e || busy !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b k=%0d: got dout=%b busy=%b expected dout=%b busy=1", k, dout, busy, e);
      end
    end
    tick();
    checks++; if (busy !== 1'b0 || dout !== 1'b1) begin errors++; $display("[TB] FAIL b2b_end: got busy=%b dout=%b expected busy=0 dout=1", busy, dout); end
  endtask

  task automatic test_handshake();
    logic e, eb;
    din = 8'h11; send = 1'b1; tick(); send = 1'b0;
    for (int k = 1; k <= 330; k++) begin
      if (k == 2) begin din = 8'h22; send = 1'b1; end
      if (k == 3) din = 8'h3C;
      if (k == 150) send = 1'b0;
      tick();
      if (k >= 3 && k <= 150) begin
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL hs_ready k=%0d: got %b expected 0", k, ready); end
      end
      if (k <= 160)      e = expBit(k, 8'h11, 16, 0, 1);
      else if (k <= 320) e = expBit(k - 160, 8'h22, 16, 0, 1);
      else               e = 1'b1;
      eb = (k <= 320);
      checks++;
      if (dout !== e || busy !== eb) begin
        errors++; $display("[TB] FAIL hs_line k=%0d: got dout=%b busy=%b expected dout=%b busy=%b", k, dout, busy, e, eb);
      end
    end
  endtask

  task automatic test_parity_stop();
    pDin = 8'h07; pSend = 1'b1; tick(); pSend = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      tick();
      checks++;
      if (pDout !== expBit(k, 8'h07, 4, 2, 2) || pBusy !== 1'b1) begin
        errors++; $display("[TB] FAIL par k=%0d: got dout=%b busy=%b expected dout=%b busy=1",
                           k, pDout, pBusy, expBit(k, 8'h07, 4, 2, 2));
      end
    end
    tick();
    checks++; if (pBusy !== 1'b0 || pDout !== 1'b1) begin errors++; $display("[TB] FAIL par_end: got busy=%b dout=%b expected busy=0 dout=1", pBusy, pDout); end
  endtask

  task automatic test_loopback();
    logic [7:0] vec [4];
    logic [7:0] rx;
    int t, strobes;
    vec[0] = 8'h00; vec[1] = 8'h55; vec[2] = 8'hFF; vec[3] = 8'h81;
    for (int i = 0; i < 4; i++) begin
      din = vec[i]; send = 1'b1; tick(); send = 1'b0;
      t = 0;
      while (dout !== 1'b0 && t < 40) begin tick(); t++; end
      checks++;
      if (t >= 40) begin
        errors++; $display("[TB] FAIL lb_start byte %0d: got no start bit expected start within 40 cycles", i);
      end else begin
        rx = 8'h00; strobes = 0;
        repeat (8) tick();
        checks++; if (dout !== 1'b0) begin errors++; $display("[TB] FAIL lb_midstart byte %0d: got %b expected 0", i, dout); end
        for (int b = 0; b < 8; b++) begin
          repeat (16) tick();
          rx[b] = dout; strobes++;
        end
        repeat (16) tick();
        checks++; if (dout !== 1'b1) begin errors++; $display("[TB] FAIL lb_stop byte %0d: got %b expected 1", i, dout); end
        checks++; if (rx !== vec[i]) begin errors++; $display("[TB] FAIL lb_data byte %0d: got %h expected %h", i, rx, vec[i]); end
        checks++; if (strobes != 8) begin errors++; $display("[TB] FAIL lb_strobes byte %0d: got %0d expected 8", i, strobes); end
      end
      t = 0;
      while (busy !== 1'b0 && t < 40) begin tick(); t++; end
      checks++;
      if (t >= 40) begin errors++; $display("[TB] FAIL lb_idle byte %0d: got busy=%b expected 0 within 40 cycles", i, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_handshake();
    test_parity_stop();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
